centerscale_scheduler: RTL and testbench

CENTERSCALE_SCHEDULER -- requirements
Module: centerscale_scheduler

---
 rtl/centerscale_scheduler.sv | 145 ++++++++++++++
 tb/tb_centerscale_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/centerscale_scheduler.sv
// Round-robin scheduler that feeds one ADC sample at a time to a shared centre/scale
// datapath, tracks the single in-flight operation and returns its result or a timeout.
module centerscale_scheduler #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                GlobalReset,
    input  logic [NCH*21-1:0]   ch_x_adc,
    input  logic [NCH-1:0]      ch_req,
    output logic [NCH-1:0]      ch_ack,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic [20:0]         dp_x_adc,
    output logic                dp_srdyi,
    output logic [31:0]         dp_mean,
    output logic [31:0]         dp_std,
    input  logic [31:0]         dp_x_centScale,
    input  logic                dp_srdyo,
    output logic [31:0]         res_data,
    output logic [1:0]          res_ch,
    output logic                res_valid,
    output logic                busy,
    output logic                timeout_err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    localparam int CW = $clog2(TIMEOUT + 2);

    state_t          state_q;
    logic [1:0]      rr_ptr_q, g_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     mean_q [NCH];
    logic [31:0]     std_q  [NCH];
    logic [20:0]     adc_ch [NCH];
    logic [NCH-1:0]  ch_ack_q;
    logic [20:0]     dp_x_adc_q;
    logic [31:0]     dp_mean_q, dp_std_q, res_data_q;
    logic [1:0]      res_ch_q;
    logic            dp_srdyi_q, res_valid_q, busy_q, timeout_err_q;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign adc_ch[i] = ch_x_adc[21*i +: 21];
    end

    // Scan downwards so the lowest offset from rr_ptr is the last (winning) hit.
    logic [2:0] idx, nxt3;
    logic [1:0] gnt_d, rr_d;
    logic       gnt_hit;
    always_comb begin
        idx     = '0;
        gnt_d   = '0;
        gnt_hit = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + 3'(k);
            if (idx >= 3'(NCH)) idx = idx - 3'(NCH);
            if (ch_req[idx[1:0]]) begin
                gnt_d   = idx[1:0];
                gnt_hit = 1'b1;
            end
        end
        nxt3 = {1'b0, gnt_d} + 3'd1;
        if (nxt3 >= 3'(NCH)) nxt3 = nxt3 - 3'(NCH);
        rr_d = nxt3[1:0];
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            for (int i = 0; i < NCH; i++) begin
                mean_q[i] <= '0;
                std_q[i]  <= '0;
            end
        end else if (cfg_we && (32'(cfg_addr[2:1]) < NCH)) begin
            if (cfg_addr[0]) std_q[cfg_addr[2:1]]  <= cfg_wdata;
            else             mean_q[cfg_addr[2:1]] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            g_q           <= '0;
            cnt_q         <= '0;
            ch_ack_q      <= '0;
            dp_x_adc_q    <= '0;
            dp_mean_q     <= '0;
            dp_std_q      <= '0;
            dp_srdyi_q    <= 1'b0;
            res_data_q    <= '0;
            res_ch_q      <= '0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            ch_ack_q    <= '0;
            dp_srdyi_q  <= 1'b0;
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (gnt_hit) begin
                    g_q        <= gnt_d;
                    rr_ptr_q   <= rr_d;
                    dp_x_adc_q <= adc_ch[gnt_d];
                    dp_mean_q  <= mean_q[gnt_d];
                    dp_std_q   <= std_q[gnt_d];
                    ch_ack_q   <= {{(NCH-1){1'b0}}, 1'b1} << gnt_d;
                    dp_srdyi_q <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (dp_srdyo) begin
                        res_data_q  <= dp_x_centScale;
                        res_ch_q    <= g_q;
                        res_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ch_ack      = ch_ack_q;
    assign dp_x_adc    = dp_x_adc_q;
    assign dp_srdyi    = dp_srdyi_q;
    assign dp_mean     = dp_mean_q;
    assign dp_std      = dp_std_q;
    assign res_data    = res_data_q;
    assign res_ch      = res_ch_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_centerscale_scheduler.sv
// Directed bench for centerscale_scheduler: an operation-timeline model is compared
// against the DUT every cycle, plus literal checks of latencies, grant order and values.
module tb_centerscale_scheduler;
    localparam int NCH     = 4;
    localparam int TIMEOUT = 31;

    logic              clk = 1'b0;
    logic              GlobalReset;
    logic [NCH*21-1:0] ch_x_adc;
    logic [NCH-1:0]    ch_req, ch_ack;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [20:0]       dp_x_adc;
    logic              dp_srdyi, dp_srdyo;
    logic [31:0]       dp_mean, dp_std, dp_x_centScale, res_data;
    logic [1:0]        res_ch;
    logic              res_valid, busy, timeout_err;

    centerscale_scheduler #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .GlobalReset(GlobalReset), .ch_x_adc(ch_x_adc), .ch_req(ch_req),
        .ch_ack(ch_ack), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .dp_x_adc(dp_x_adc), .dp_srdyi(dp_srdyi), .dp_mean(dp_mean), .dp_std(dp_std),
        .dp_x_centScale(dp_x_centScale), .dp_srdyo(dp_srdyo), .res_data(res_data),
        .res_ch(res_ch), .res_valid(res_valid), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Datapath stand-in: result appears dp_lat cycles after the ISSUE cycle (0 = never).
    int   dp_lat = 18, dly = 0;
    logic fire = 1'b0, spur = 1'b0;
    logic [31:0] dp_result = '0;
    assign dp_srdyo       = fire | spur;
    assign dp_x_centScale = dp_result;
    always @(negedge clk) begin
        fire <= 1'b0;
        if (dp_srdyi) dly <= dp_lat;
        else if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) fire <= 1'b1;
        end
    end

    // Model: an operation has an age in cycles since its grant (-1 = none in flight).
    function automatic int pick(input logic [NCH-1:0] req, input int rr);
        for (int k = 0; k < NCH; k++) if (req[(rr + k) % NCH]) return (rr + k) % NCH;
        return -1;
    endfunction

    int          m_age, m_rr, m_g;
    logic [3:0]  m_ack;
    logic        m_srdyi, m_rv, m_busy, m_err;
    logic [20:0] m_x;
    logic [31:0] m_mean, m_std, m_rd;
    logic [1:0]  m_rch;
    logic [31:0] m_tmean [NCH];
    logic [31:0] m_tstd  [NCH];

    always @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            m_age <= -1; m_rr <= 0; m_g <= 0; m_ack <= '0; m_srdyi <= 0; m_rv <= 0;
            m_busy <= 0; m_err <= 0; m_x <= '0; m_mean <= '0; m_std <= '0; m_rd <= '0;
            m_rch <= '0;
            for (int i = 0; i < NCH; i++) begin m_tmean[i] <= '0; m_tstd[i] <= '0; end
        end else begin
            m_ack <= '0; m_srdyi <= 0; m_rv <= 0;
            if (m_age < 0) begin
                if (pick(ch_req, m_rr) >= 0) begin
                    m_g    <= pick(ch_req, m_rr);
                    m_rr   <= (pick(ch_req, m_rr) + 1) % NCH;
                    m_age  <= 0;
                    m_ack  <= 4'b0001 << pick(ch_req, m_rr);
                    m_srdyi <= 1; m_busy <= 1;
                    m_x    <= ch_x_adc[21*pick(ch_req, m_rr) +: 21];
                    m_mean <= m_tmean[pick(ch_req, m_rr)];
                    m_std  <= m_tstd[pick(ch_req, m_rr)];
                end
            end else if (m_age == 0) m_age <= 1;
            else if (dp_srdyo) begin
                m_rv <= 1; m_rd <= dp_x_centScale; m_rch <= 2'(m_g); m_busy <= 0; m_age <= -1;
            end else if (m_age - 1 == TIMEOUT) begin
                m_err <= 1; m_busy <= 0; m_age <= -1;
            end else m_age <= m_age + 1;
            if (cfg_we) begin
                if (cfg_addr[0]) m_tstd[cfg_addr[2:1]]  <= cfg_wdata;
                else             m_tmean[cfg_addr[2:1]] <= cfg_wdata;
            end
        end
    end

    always @(negedge clk) begin
        chk("ch_ack", 32'(ch_ack), 32'(m_ack));
        chk("dp_srdyi", 32'(dp_srdyi), 32'(m_srdyi));
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        chk("dp_x_adc", 32'(dp_x_adc), 32'(m_x));
        chk("dp_mean", dp_mean, m_mean);
        chk("dp_std", dp_std, m_std);
        chk("res_data", res_data, m_rd);
        chk("res_ch", 32'(res_ch), 32'(m_rch));
    end

    // Requester side: snapshot issue/result values, drop ch_req bits once acknowledged.
    bit          drop = 1'b1;
    int          ack_q[$];
    int          rv_cnt = 0;
    logic [3:0]  l_ack;
    logic        l_srdyi;
    logic [20:0] l_x;
    logic [31:0] l_mean, l_std, l_rd;
    logic [1:0]  l_rch;

    task automatic cyc();
        @(negedge clk);
        if (ch_ack != '0) begin
            for (int i = 0; i < NCH; i++) if (ch_ack[i]) ack_q.push_back(i);
            l_ack = ch_ack; l_srdyi = dp_srdyi; l_x = dp_x_adc; l_mean = dp_mean; l_std = dp_std;
            if (drop) ch_req = ch_req & ~ch_ack;
        end
        if (res_valid) begin rv_cnt++; l_rd = res_data; l_rch = res_ch; end
    endtask

    task automatic wait_rv(input int maxc, output int lat);
        lat = 0;
        do begin cyc(); lat++; end while (!res_valid && lat < maxc);
        if (!res_valid) chk("rv_wait_expired", 32'(lat), 32'(maxc + 1));
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc();
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int lat, rv0, busy_n;
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    initial begin
        GlobalReset = 1'b0; ch_req = '0; ch_x_adc = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        #1 GlobalReset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ch_ack), 0);
        chk("rst_res", res_data, 0);
        GlobalReset = 1'b0;

        // Round robin with all requests held
        for (int i = 0; i < NCH; i++) ch_x_adc[21*i +: 21] = 21'h100 + 21'(i);
        drop = 1'b0; ch_req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            dp_result = 32'hA000_0000 + 32'(n);
            wait_rv(40, lat);
            chk("rr_latency", 32'(lat), 20);
        end
        ch_req = '0; drop = 1'b1;
        chk("rr_count", 32'(ack_q.size()), 5);
        for (int n = 0; n < 5 && n < ack_q.size(); n++) chk("rr_order", 32'(ack_q[n]), 32'(exp_ord[n]));
        cyc();

        // Single channel
        cfg_write(3'b010, 32'hC000_0000);
        cfg_write(3'b011, 32'h3F00_0000);
        ch_x_adc[21 +: 21] = 21'h0A5A5A; dp_result = 32'h1234_5678; rv0 = rv_cnt;
        ch_req = 4'b0010;
        wait_rv(40, lat);
        chk("sc_latency", 32'(lat), 20);
        chk("sc_ack", 32'(l_ack), 32'h2);
        chk("sc_srdyi", 32'(l_srdyi), 1);
        chk("sc_x", 32'(l_x), 32'h0A5A5A);
        chk("sc_mean", l_mean, 32'hC000_0000);
        chk("sc_std", l_std, 32'h3F00_0000);
        chk("sc_res", l_rd, 32'h1234_5678);
        chk("sc_ch", 32'(l_rch), 1);
        repeat (3) cyc();
        chk("sc_rv_count", 32'(rv_cnt - rv0), 1);

        // Spurious dp_srdyo while idle
        spur = 1'b1; cyc(); spur = 1'b0;
        repeat (3) cyc();
        chk("spur_rv_count", 32'(rv_cnt - rv0), 1);
        chk("spur_res_hold", res_data, 32'h1234_5678);

        // Timeout, then a normal operation still served
        dp_lat = 0; rv0 = rv_cnt; busy_n = 0; ch_req = 4'b0100;
        for (int n = 0; n < 45; n++) begin cyc(); if (busy) busy_n++; end
        chk("to_busy_cycles", 32'(busy_n), 32'(TIMEOUT + 2));
        chk("to_no_rv", 32'(rv_cnt - rv0), 0);
        chk("to_err", 32'(timeout_err), 1);
        dp_lat = 18; dp_result = 32'h0BAD_CAFE; ch_req = 4'b1000;
        wait_rv(40, lat);
        chk("to_next_latency", 32'(lat), 20);
        chk("to_next_ch", 32'(l_rch), 3);
        chk("to_err_sticky", 32'(timeout_err), 1);

        // Config write to the channel in flight
        ch_req = 4'b0001; dp_result = 32'h5555_AAAA;
        repeat (5) cyc();
        cfg_write(3'b000, 32'h4040_0000);
        repeat (2) cyc();
        chk("flight_mean_held", dp_mean, 32'h0);
        wait_rv(40, lat);
        chk("flight_latency", 32'(lat), 12);
        ch_req = 4'b0001;
        wait_rv(40, lat);
        chk("flight_next_mean", l_mean, 32'h4040_0000);

        // Reset in WAIT cycle 5; the late datapath result must be dropped
        ch_req = 4'b0010;
        repeat (7) cyc();
        #2 GlobalReset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_mean", dp_mean, 0);
        chk("mid_rst_x", 32'(dp_x_adc), 0);
        chk("mid_rst_res", res_data, 0);
        chk("mid_rst_err", 32'(timeout_err), 0);
        cyc(); cyc();
        GlobalReset = 1'b0; rv0 = rv_cnt;
        repeat (20) cyc();
        chk("mid_rst_no_rv", 32'(rv_cnt - rv0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
